jtcps1_sdram_arb: RTL and testbench



---
 rtl/jtcps1_sdram_arb_pkg.sv | 30 +++
 rtl/jtcps1_rr_pick.sv | 27 ++
 rtl/jtcps1_sdram_arb.sv | 187 ++++++++++++++++++
 tb/tb_jtcps1_sdram_arb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtcps1_sdram_arb_pkg.sv
// Shared types and constants for the CPS1 SDRAM bank arbiter.
package jtcps1_sdram_arb_pkg;

  localparam int unsigned NBANK = 4;
  localparam int unsigned BAW   = 2;
  localparam int unsigned DW    = 16;
  localparam int unsigned MW    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RFSH = 2'd3
  } arb_state_e;

  localparam logic [BAW-1:0] BA_RAM = 2'd0;
  localparam logic [BAW-1:0] BA_SND = 2'd1;
  localparam logic [BAW-1:0] BA_GFX = 2'd2;
  localparam logic [BAW-1:0] BA_ROM = 2'd3;

  typedef struct packed {
    logic [DW-1:0] din;
    logic [MW-1:0] mask;
  } wdata_t;

  function automatic logic [NBANK-1:0] bank_onehot(input logic [BAW-1:0] idx);
    return NBANK'(1) << idx;
  endfunction

endpackage

// File: rtl/jtcps1_rr_pick.sv
// Combinational 4-way round-robin picker: first requester after last_i, wrapping.
module jtcps1_rr_pick
  import jtcps1_sdram_arb_pkg::*;
(
  input  logic [NBANK-1:0] req_i,
  input  logic [BAW-1:0]   last_i,
  output logic             valid_o,
  output logic [BAW-1:0]   idx_o
);

  logic [BAW-1:0] cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = last_i;
    cand    = last_i;
    // last_i itself is searched last, so a lone requester may be re-granted
    for (int k = 1; k <= 4; k++) begin
      cand = last_i + BAW'(k);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/jtcps1_sdram_arb.sv
// Round-robin arbiter of four bank ports onto one SDRAM command port,
// with auto-refresh insertion during the refresh window.
module jtcps1_sdram_arb
  import jtcps1_sdram_arb_pkg::*;
#(
  parameter int unsigned AW          = 22,
  parameter int unsigned RFSH_PERIOD = 64,
  parameter int unsigned RFSH_CW     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              refresh_en,
  input  logic [4*AW-1:0]   ba_addr,
  input  logic [3:0]        ba_rd,
  input  logic              ba0_wr,
  input  logic [15:0]       ba0_din,
  input  logic [1:0]        ba0_din_m,
  output logic [3:0]        ba_ack,
  output logic [3:0]        ba_rdy,
  output logic [AW-1:0]     sd_addr,
  output logic [1:0]        sd_ba,
  output logic              sd_rd,
  output logic              sd_wr,
  output logic              sd_rfsh,
  output logic [15:0]       sd_din,
  output logic [1:0]        sd_din_m,
  input  logic              sd_ack,
  input  logic              sd_rdy
);

  localparam logic [RFSH_CW-1:0] RFSH_LAST = RFSH_CW'(RFSH_PERIOD - 1);

  arb_state_e         state_q, state_d;
  logic [BAW-1:0]     grant_q, grant_d;
  logic [BAW-1:0]     last_q, last_d;
  logic [AW-1:0]      addr_q, addr_d;
  wdata_t             wdata_q, wdata_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic               rfsh_q, rfsh_d;
  logic [RFSH_CW-1:0] rfsh_cnt_q, rfsh_cnt_d;
  logic               rfsh_pend_q, rfsh_pend_d;
  logic               rfsh_done;

  logic [NBANK-1:0]   req;
  logic               pick_valid;
  logic [BAW-1:0]     pick_idx;
  logic [AW-1:0]      pick_addr;
  logic               pick_wr;

  assign req       = ba_rd | {3'b000, ba0_wr};
  assign pick_addr = ba_addr[32'(pick_idx) * AW +: AW];
  // a bank-0 write outranks a simultaneous bank-0 read
  assign pick_wr   = (pick_idx == BA_RAM) && ba0_wr;

  jtcps1_rr_pick u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; refresh takes priority over any pending request
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rfsh_pend_q)     state_d = ST_RFSH;
        else if (pick_valid) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (sd_ack) state_d = sd_rdy ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (sd_rdy) state_d = ST_IDLE;
      end
      ST_RFSH: begin
        if (sd_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: command field next-values plus same-cycle ack/rdy routing
  always_comb begin
    grant_d   = grant_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    rfsh_d    = rfsh_q;
    rfsh_done = 1'b0;
    ba_ack    = '0;
    ba_rdy    = '0;
    case (state_q)
      ST_IDLE: begin
        if (rfsh_pend_q) begin
          rfsh_d = 1'b1;
        end else if (pick_valid) begin
          grant_d = pick_idx;
          addr_d  = pick_addr;
          wdata_d = '{din: ba0_din, mask: ba0_din_m};
          wr_d    = pick_wr;
          rd_d    = !pick_wr;
        end
      end
      ST_CMD: begin
        if (sd_ack) begin
          ba_ack = bank_onehot(grant_q);
          ba_rdy = sd_rdy ? bank_onehot(grant_q) : '0;
          rd_d   = 1'b0;
          wr_d   = 1'b0;
          last_d = grant_q;
        end
      end
      ST_WAIT: begin
        if (sd_rdy) ba_rdy = bank_onehot(grant_q);
      end
      ST_RFSH: begin
        if (sd_ack) begin
          rfsh_d    = 1'b0;
          rfsh_done = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Refresh timer: at most one refresh pending; a wrap on the ack cycle re-arms it
  always_comb begin
    rfsh_cnt_d  = rfsh_cnt_q;
    rfsh_pend_d = rfsh_pend_q;
    if (!refresh_en) begin
      rfsh_cnt_d  = '0;
      rfsh_pend_d = 1'b0;
    end else begin
      if (rfsh_done) rfsh_pend_d = 1'b0;
      if (rfsh_cnt_q == RFSH_LAST) begin
        rfsh_cnt_d  = '0;
        rfsh_pend_d = 1'b1;
      end else begin
        rfsh_cnt_d = rfsh_cnt_q + RFSH_CW'(1);
      end
    end
  end

  // Datapath and refresh registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q     <= BA_RAM;
      last_q      <= BA_ROM;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rfsh_q      <= 1'b0;
      rfsh_cnt_q  <= '0;
      rfsh_pend_q <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      rfsh_q      <= rfsh_d;
      rfsh_cnt_q  <= rfsh_cnt_d;
      rfsh_pend_q <= rfsh_pend_d;
    end
  end

  assign sd_addr  = addr_q;
  assign sd_ba    = grant_q;
  assign sd_rd    = rd_q;
  assign sd_wr    = wr_q;
  assign sd_rfsh  = rfsh_q;
  assign sd_din   = wdata_q.din;
  assign sd_din_m = wdata_q.mask;

endmodule

// File: tb/tb_jtcps1_sdram_arb.sv
// Scoreboard bench for jtcps1_sdram_arb with a behavioural SDRAM controller responder.
module tb_jtcps1_sdram_arb;
  import jtcps1_sdram_arb_pkg::*;

  localparam int unsigned AW = 22;
  localparam logic [1:0] K_RD = 2'd0, K_WR = 2'd1, K_RFSH = 2'd2;

  typedef struct packed {
    logic [1:0]    kind;
    logic [1:0]    ba;
    logic [AW-1:0] addr;
    logic [15:0]   din;
    logic [1:0]    mask;
  } cmd_t;

  logic            clk, rst, refresh_en;
  logic [4*AW-1:0] ba_addr;
  logic [3:0]      ba_rd;
  logic            ba0_wr;
  logic [15:0]     ba0_din;
  logic [1:0]      ba0_din_m;
  logic [3:0]      ba_ack, ba_rdy;
  logic [AW-1:0]   sd_addr;
  logic [1:0]      sd_ba;
  logic            sd_rd, sd_wr, sd_rfsh;
  logic [15:0]     sd_din;
  logic [1:0]      sd_din_m;
  logic            sd_ack, sd_rdy;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int cmd_cnt = 0, done_cnt = 0, ack_cnt = 0;
  int ack_dly = 2, rdy_dly = 3;
  bit same_cyc = 0, gap_chk = 0, want_first = 0;
  int rdy_cyc = 0, rfsh_t0 = 0;
  cmd_t sb_q[$];

  jtcps1_sdram_arb #(.AW(AW), .RFSH_PERIOD(64), .RFSH_CW(7)) dut (
    .clk(clk), .rst(rst), .refresh_en(refresh_en),
    .ba_addr(ba_addr), .ba_rd(ba_rd), .ba0_wr(ba0_wr),
    .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
    .ba_ack(ba_ack), .ba_rdy(ba_rdy),
    .sd_addr(sd_addr), .sd_ba(sd_ba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_rfsh(sd_rfsh), .sd_din(sd_din), .sd_din_m(sd_din_m),
    .sd_ack(sd_ack), .sd_rdy(sd_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] bank_addr(input int n);
    return AW'(32'h01_0000 * (n + 1) + n);
  endfunction

  task automatic push_exp(input logic [1:0] kind, input logic [1:0] ba, input logic [AW-1:0] addr,
                          input logic [15:0] din, input logic [1:0] mask);
    cmd_t c;
    c.kind = kind; c.ba = ba; c.addr = addr; c.din = din; c.mask = mask;
    sb_q.push_back(c);
  endtask

  function automatic int cnt_sel(input int sel);
    return (sel == 0) ? cmd_cnt : (sel == 1) ? done_cnt : ack_cnt;
  endfunction

  // sel: 0 = commands seen, 1 = transactions completed, 2 = acks given
  task automatic wait_cnt(input string tag, input int sel, input int target);
    int n = 0;
    while (cnt_sel(sel) < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check_val({tag, "_timeout"}, 64'(cnt_sel(sel)), 64'(target));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({sd_rd, sd_wr, sd_rfsh, sd_ba, sd_addr, sd_din, sd_din_m, ba_ack, ba_rdy});
  endfunction

  // Controller model: checks each new command against the scoreboard, then acks it
  task automatic serve_cmd();
    cmd_t obs, exp;
    logic [3:0] oh;
    logic [63:0] snap;
    bit aborted = 0;
    obs.kind = sd_rfsh ? K_RFSH : (sd_wr ? K_WR : K_RD);
    obs.ba = sd_ba; obs.addr = sd_addr; obs.din = sd_din; obs.mask = sd_din_m;
    snap = 64'({sd_rd, sd_wr, sd_rfsh, sd_ba, sd_addr, sd_din, sd_din_m});
    cmd_cnt++;
    if (gap_chk) begin
      check_val("cmd_gap", 64'(cyc - rdy_cyc), 64'(2));
      gap_chk = 0;
    end
    if (want_first && obs.kind == K_RFSH) begin
      check_val("rfsh_first", 64'(cyc - rfsh_t0), 64'(64));
      want_first = 0;
    end
    if (sb_q.size() == 0) begin
      check_val("sb_unexpected", 64'(obs), 64'(0));
    end else begin
      exp = sb_q.pop_front();
      check_val("cmd_kind", 64'(obs.kind), 64'(exp.kind));
      if (exp.kind != K_RFSH) begin
        check_val("cmd_ba", 64'(obs.ba), 64'(exp.ba));
        check_val("cmd_addr", 64'(obs.addr), 64'(exp.addr));
      end
      if (exp.kind == K_WR) begin
        check_val("cmd_din", 64'(obs.din), 64'(exp.din));
        check_val("cmd_mask", 64'(obs.mask), 64'(exp.mask));
      end
    end
    check_val("no_pulse_pre", 64'({ba_ack, ba_rdy}), 64'(0));
    for (int i = 0; i < ack_dly && !aborted; i++) begin
      @(negedge clk);
      if (rst) aborted = 1;
    end
    if (aborted) return;
    check_val("cmd_hold", 64'({sd_rd, sd_wr, sd_rfsh, sd_ba, sd_addr, sd_din, sd_din_m}), snap);
    oh = (obs.kind == K_RFSH) ? 4'b0000 : (4'b0001 << obs.ba);
    sd_ack = 1'b1;
    if (same_cyc) sd_rdy = 1'b1;
    ack_cnt++;
    #1;
    check_val("ba_ack", 64'(ba_ack), 64'(oh));
    if (same_cyc || obs.kind == K_RFSH) begin
      check_val("ba_rdy_ack", 64'(ba_rdy), 64'(same_cyc ? oh : 4'b0000));
      rdy_cyc = cyc;
    end
    @(negedge clk);
    sd_ack = 1'b0;
    sd_rdy = 1'b0;
    #1;
    check_val("cmd_drop", 64'({sd_rd, sd_wr, sd_rfsh}), 64'(0));
    if (!same_cyc && obs.kind != K_RFSH) begin
      for (int i = 0; i < rdy_dly && !aborted; i++) begin
        @(negedge clk);
        if (rst) aborted = 1;
      end
      if (aborted) return;
      sd_rdy = 1'b1;
      #1;
      check_val("ba_rdy", 64'(ba_rdy), 64'(oh));
      rdy_cyc = cyc;
      @(negedge clk);
      sd_rdy = 1'b0;
    end
    done_cnt++;
  endtask

  initial begin : ctrl_model
    sd_ack = 1'b0;
    sd_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && (sd_rd || sd_wr || sd_rfsh)) serve_cmd();
    end
  end

  initial begin : watchdog
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int c_base, d_base;
    rst = 1'b1; refresh_en = 1'b0; ba_addr = '0; ba_rd = '0;
    ba0_wr = 1'b0; ba0_din = '0; ba0_din_m = '0;
    repeat (3) @(negedge clk);
    check_val("reset_outs", all_outs(), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_outs", all_outs(), 64'(0));

    // Round robin with all read ports held
    for (int n = 0; n < 4; n++) ba_addr[n*AW +: AW] = bank_addr(n);
    for (int n = 0; n < 5; n++) push_exp(K_RD, 2'(n % 4), bank_addr(n % 4), '0, '0);
    c_base = cmd_cnt; d_base = done_cnt;
    ba_rd = 4'b1111;
    wait_cnt("rr_cmd", 0, c_base + 5);
    ba_rd = 4'b0000;
    wait_cnt("rr_done", 1, d_base + 5);

    // Bank-0 write with a simultaneous bank-0 read
    ba_addr[0 +: AW] = 22'h10_0004;
    ba0_din = 16'hA55A; ba0_din_m = 2'b01;
    push_exp(K_WR, BA_RAM, 22'h10_0004, 16'hA55A, 2'b01);
    c_base = cmd_cnt; d_base = done_cnt;
    ba0_wr = 1'b1; ba_rd = 4'b0001;
    wait_cnt("wr_cmd", 0, c_base + 1);
    ba0_wr = 1'b0; ba_rd = 4'b0000;
    wait_cnt("wr_done", 1, d_base + 1);

    // ack and rdy in the same cycle, request held for two transactions
    same_cyc = 1;
    push_exp(K_RD, BA_SND, bank_addr(1), '0, '0);
    push_exp(K_RD, BA_SND, bank_addr(1), '0, '0);
    c_base = cmd_cnt; d_base = done_cnt;
    ba_rd = 4'b0010;
    wait_cnt("same_cmd1", 0, c_base + 1);
    gap_chk = 1;
    wait_cnt("same_cmd2", 0, c_base + 2);
    ba_rd = 4'b0000;
    wait_cnt("same_done", 1, d_base + 2);
    same_cyc = 0;
    check_val("gap_checked", 64'(gap_chk), 64'(0));

    // 200-cycle refresh window, no requests
    ack_dly = 1;
    repeat (3) push_exp(K_RFSH, '0, '0, '0, '0);
    c_base = cmd_cnt;
    refresh_en = 1'b1;
    rfsh_t0 = cyc + 1;
    want_first = 1;
    repeat (200) @(negedge clk);
    refresh_en = 1'b0;
    check_val("rfsh_count", 64'(cmd_cnt - c_base), 64'(3));
    repeat (70) @(negedge clk);
    check_val("rfsh_off", 64'(cmd_cnt - c_base), 64'(3));
    check_val("rfsh_first_seen", 64'(want_first), 64'(0));

    // Refresh pending and bank-3 request seen in the same idle cycle
    ack_dly = 2;
    push_exp(K_RFSH, '0, '0, '0, '0);
    push_exp(K_RD, BA_ROM, bank_addr(3), '0, '0);
    c_base = cmd_cnt; d_base = done_cnt;
    refresh_en = 1'b1;
    repeat (64) @(negedge clk);
    ba_rd = 4'b1000;
    wait_cnt("prio_cmd", 0, c_base + 2);
    ba_rd = 4'b0000;
    refresh_en = 1'b0;
    wait_cnt("prio_done", 1, d_base + 2);

    // Reset in WAIT, then the held request is re-issued
    rdy_dly = 20;
    push_exp(K_RD, BA_GFX, bank_addr(2), '0, '0);
    push_exp(K_RD, BA_GFX, bank_addr(2), '0, '0);
    c_base = cmd_cnt; d_base = done_cnt;
    ba_rd = 4'b0100;
    wait_cnt("rst_ack", 2, ack_cnt + 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst_async", all_outs(), 64'(0));
    @(negedge clk);
    check_val("rst_held", all_outs(), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    rdy_dly = 3;
    wait_cnt("rst_recmd", 0, c_base + 2);
    ba_rd = 4'b0000;
    wait_cnt("rst_done", 1, d_base + 1);
    repeat (5) @(negedge clk);

    check_val("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
